// File: rtl/wddl_rail_decoder.sv
// WDDL dual-rail to single-rail decoder with spacer/evaluate completion checks and valid/ready output.
// Define WDDL_DEC_SYNC_EN to pass rails and precharge through a two-stage synchronizer first.
module wddl_rail_decoder #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             precharge,
    input  logic [WIDTH-1:0] in_t,
    input  logic [WIDTH-1:0] in_f,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_valid,
    output logic [1:0]       err_code,
    input  logic             err_clr
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_COLLISION = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b10;
    localparam logic [1:0] ERR_PREMATURE = 2'b11;

    typedef enum logic [1:0] {
        S_PRE   = 2'd0,
        S_EVAL  = 2'd1,
        S_OUT   = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    logic             pc_s;
    logic [WIDTH-1:0] t_s;
    logic [WIDTH-1:0] f_s;

`ifdef WDDL_DEC_SYNC_EN
    logic             pc_q1, pc_q2;
    logic [WIDTH-1:0] t_q1, t_q2;
    logic [WIDTH-1:0] f_q1, f_q2;

    // Two-flop synchronizer in front of all decode logic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q1 <= 1'b0;
            pc_q2 <= 1'b0;
            t_q1  <= '0;
            t_q2  <= '0;
            f_q1  <= '0;
            f_q2  <= '0;
        end else begin
            pc_q1 <= precharge;
            pc_q2 <= pc_q1;
            t_q1  <= in_t;
            t_q2  <= t_q1;
            f_q1  <= in_f;
            f_q2  <= f_q1;
        end
    end

    assign pc_s = pc_q2;
    assign t_s  = t_q2;
    assign f_s  = f_q2;
`else
    assign pc_s = precharge;
    assign t_s  = in_t;
    assign f_s  = in_f;
`endif

    logic spacer_c;
    logic complete_c;
    logic collision_c;

    assign spacer_c    = ~|(t_s | f_s);
    assign complete_c  = &(t_s ^ f_s);
    assign collision_c = |(t_s & f_s);

    state_e           state_q;
    logic             armed_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] data_q;
    logic             out_valid_q;
    logic             err_valid_q;
    logic [1:0]       err_code_q;

    // Phase FSM; every output is a register updated here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_PRE;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            case (state_q)
                S_PRE: begin
                    if (pc_s) begin
                        if (spacer_c) armed_q <= 1'b1;
                    end else if (armed_q) begin
                        state_q <= S_EVAL;
                        cnt_q   <= '0;
                        armed_q <= 1'b0;
                    end
                end
                S_EVAL: begin
                    if (collision_c) begin
                        state_q     <= S_FAULT;
                        err_valid_q <= 1'b1;
                        err_code_q  <= ERR_COLLISION;
                    end else if (complete_c) begin
                        state_q     <= S_OUT;
                        data_q      <= t_s;
                        out_valid_q <= 1'b1;
                    end else if (pc_s) begin
                        state_q     <= S_FAULT;
                        err_valid_q <= 1'b1;
                        err_code_q  <= ERR_PREMATURE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q     <= S_FAULT;
                        err_valid_q <= 1'b1;
                        err_code_q  <= ERR_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_OUT: begin
                    // Handshake done: a fresh spacer is needed before the next word
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_PRE;
                        armed_q     <= 1'b0;
                    end
                end
                S_FAULT: begin
                    if (err_clr) begin
                        err_valid_q <= 1'b0;
                        err_code_q  <= ERR_NONE;
                        state_q     <= S_PRE;
                        armed_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_PRE;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign out_valid = out_valid_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_wddl_rail_decoder.sv
// Directed bench for wddl_rail_decoder; accepted words are checked against a scoreboard queue.
module tb_wddl_rail_decoder;

    localparam int unsigned W  = 8;
    localparam int unsigned TO = 16;
`ifdef WDDL_DEC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         precharge;
    logic [W-1:0] in_t;
    logic [W-1:0] in_f;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic         out_ready;
    logic         err_valid;
    logic [1:0]   err_code;
    logic         err_clr;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    wddl_rail_decoder #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .precharge (precharge),
        .in_t      (in_t),
        .in_f      (in_f),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_valid (err_valid),
        .err_code  (err_code),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic spacer(input int n);
        precharge = 1'b1;
        in_t      = '0;
        in_f      = '0;
        cyc(n);
    endtask

    task automatic drive(input logic [W-1:0] t, input logic [W-1:0] f);
        precharge = 1'b0;
        in_t      = t;
        in_f      = f;
    endtask

    // Bounded wait: sel 0 = out_valid, 1 = err_valid; k = cycles taken (limit on expiry)
    task automatic wait_sig(input int sel, input int limit, output int k);
        k = 0;
        while (k < limit) begin
            cyc(1);
            k++;
            if ((sel == 0 && out_valid) || (sel == 1 && err_valid)) break;
        end
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
    endtask

    // Scoreboard: every accepted word must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_word", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
                chk("sb_word", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int k;
        int seen;
        rst       = 1'b1;
        precharge = 1'b0;
        in_t      = '0;
        in_f      = '0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        cyc(2);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        chk("rst_err_code",  32'(err_code),  32'd0);
        chk("rst_data",      32'(data_out),  32'd0);
        rst = 1'b0;

        // Normal word
        spacer(4);
        exp_q.push_back(8'hA5);
        drive(8'hA5, 8'h5A);
        wait_sig(0, 20, k);
        chk("t1_latency", 32'(k), 32'(LAT + 1));
        chk("t1_data", 32'(data_out), 32'hA5);
        cyc(1);
        chk("t1_valid_drop", 32'(out_valid), 32'd0);

        // Staggered arrival with backpressure
        out_ready = 1'b0;
        spacer(4);
        exp_q.push_back(8'h3C);
        drive(8'h0C, 8'h03);
        cyc(1);
        drive(8'h3C, 8'h03);
        cyc(1);
        chk("t2_no_early_valid", 32'(out_valid), 32'd0);
        drive(8'h3C, 8'hC3);
        wait_sig(0, 20, k);
        chk("t2_latency", 32'(k), 32'(LAT));
        drive(8'hFF, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            chk("t2_stall_data",  32'(data_out),  32'h3C);
            chk("t2_stall_valid", 32'(out_valid), 32'd1);
            chk("t2_stall_err",   32'(err_valid), 32'd0);
            cyc(1);
        end
        out_ready = 1'b1;
        cyc(1);
        chk("t2_valid_drop", 32'(out_valid), 32'd0);

        // Collision
        spacer(4);
        drive(8'h08, 8'h08);
        wait_sig(1, 20, k);
        chk("t3_latency",   32'(k),         32'(LAT + 1));
        chk("t3_code",      32'(err_code),  32'd1);
        chk("t3_out_valid", 32'(out_valid), 32'd0);
        chk("t3_data_hold", 32'(data_out),  32'h3C);
        clear_err();
        chk("t3_clr_valid", 32'(err_valid), 32'd0);
        chk("t3_clr_code",  32'(err_code),  32'd0);

        // Timeout: bit 0 never resolves
        spacer(4);
        drive(8'hFE, 8'h00);
        wait_sig(1, 40, k);
        chk("t4_latency",   32'(k),         32'(LAT + TO));
        chk("t4_code",      32'(err_code),  32'd2);
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        clear_err();

        // Premature precharge after four incomplete evaluate cycles
        spacer(4);
        drive(8'h0F, 8'h00);
        cyc(5);
        chk("t5_no_early_err", 32'(err_valid), 32'd0);
        spacer(0);
        wait_sig(1, 20, k);
        chk("t5_latency", 32'(k),        32'(LAT));
        chk("t5_code",    32'(err_code), 32'd3);
        // Evaluate with no preceding spacer must be ignored
        drive(8'hA5, 8'h5A);
        cyc(4);
        clear_err();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (out_valid) seen++;
        end
        chk("t5_ignored_word", 32'(seen), 32'd0);
        chk("t5_err_clear",    32'(err_valid), 32'd0);

        // Reset while holding a word in OUT
        out_ready = 1'b0;
        spacer(4);
        drive(8'h77, 8'h88);
        wait_sig(0, 20, k);
        chk("t6_reach_out", 32'(out_valid), 32'd1);
        chk("t6_data",      32'(data_out),  32'h77);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_err",   32'(err_valid), 32'd0);
        chk("t6_rst_data",  32'(data_out),  32'd0);
        cyc(1);
        rst       = 1'b0;
        out_ready = 1'b1;

        // Recovery after reset
        spacer(4);
        exp_q.push_back(8'h96);
        drive(8'h96, 8'h69);
        wait_sig(0, 20, k);
        chk("t7_latency", 32'(k), 32'(LAT + 1));
        cyc(2);
        spacer(1);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wddl_rail_decoder.md
Name: wddl_rail_decoder

Overview:
- Converts a WIDTH-bit WDDL dual-rail bus (true/false rails, precharge/evaluate phases) back to single-rail registered data at the boundary between the differential AES datapath and standard logic.
- Checks spacer and evaluate completeness and detects rail collisions, timeouts and premature precharge.
- Delivers each evaluated word through a valid/ready handshake.

Parameters:
- WIDTH, 8, number of dual-rail bits decoded.
- TIMEOUT, 16, maximum evaluate-phase cycles allowed before completion; must be >= 2.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- precharge  input  1  phase from WDDL controller: 1 = precharge, 0 = evaluate.
- in_t  input  WIDTH  true rails.
- in_f  input  WIDTH  false rails.
- data_out  output  WIDTH  decoded word (in_t value at completion).
- out_valid  output  1  data_out valid; held until accepted.
- out_ready  input  1  consumer accepts data_out when out_valid & out_ready.
- err_valid  output  1  sticky fault indication.
- err_code  output  2  00 none, 01 collision, 10 timeout, 11 premature precharge.
- err_clr  input  1  clears the fault and returns to PRE.

Behaviour:
- Reset (async, active-high) state:
  - State = PRE; armed = 0; eval counter = 0.
  - data_out = 0, out_valid = 0, err_valid = 0, err_code = 00.
  - Reset mid-operation discards any word in flight.
- Derived per-cycle terms:
  - spacer = all in_t|in_f bits are 0.
  - complete = every bit has in_t^in_f = 1.
  - collision = any bit has in_t&in_f = 1.
- PRE:
  - precharge=1 and spacer sets armed.
  - precharge=0 and armed: go to EVAL, counter cleared, armed cleared.
  - precharge=0 without armed: stay in PRE; the word is ignored and no error is raised.
- EVAL: evaluated every cycle in this priority order.
  1. collision: go to FAULT, err_code=01.
  2. complete: data_out<=in_t, out_valid<=1, go to OUT.
  3. precharge=1: go to FAULT, err_code=11.
  4. counter==TIMEOUT-1: go to FAULT, err_code=10.
  5. Otherwise counter++.
  - Completion sampled in cycle N gives out_valid=1 in cycle N+1.
  - The first EVAL cycle counts as counter=0, so timeout fires after exactly TIMEOUT incomplete EVAL cycles.
- OUT:
  - out_valid stays 1 and data_out is stable while out_ready=0.
  - Rail and precharge activity is ignored.
  - On out_valid&out_ready: out_valid<=0 next cycle, go to PRE with armed=0, so a fresh spacer is required.
- FAULT:
  - err_valid=1; err_code held.
  - data_out keeps its last accepted value; out_valid=0.
  - err_clr: err_valid<=0, err_code<=00, go to PRE with armed=0.
- Simultaneous events:
  - err_clr outside FAULT is ignored.
  - out_ready with out_valid=0 is ignored.
- Counter width: clog2(TIMEOUT); saturation is never reached because the FAULT transition occurs first.

Optional Feature:
- Macro WDDL_DEC_SYNC_EN.
- Defined:
  - in_t, in_f and precharge pass through a two-stage register synchronizer (reset to 0) before all decode logic.
  - Completion-to-out_valid latency becomes 3 cycles.
  - Collision, timeout and premature-precharge detection operate on the synchronized values.
- Undefined:
  - Inputs feed the decode logic directly; latency is 1 cycle.

Test Plan:
1. Normal word (sync off):
   - Stimulus: release rst; precharge=1, rails 0 for 2 cycles; then precharge=0, in_t=8'hA5, in_f=8'h5A.
   - Response: out_valid=1 and data_out=8'hA5 the next cycle; with out_ready=1, out_valid=0 one cycle later and state returns to PRE.
2. Staggered arrival with backpressure:
   - Stimulus: bits resolve over 3 EVAL cycles; out_ready=0 for 5 cycles.
   - Response: out_valid rises one cycle after the last bit; data_out holds 8'h3C unchanged through the stall; err_valid=0.
3. Collision:
   - Stimulus: during EVAL, in_t=in_f=8'h08.
   - Response: next cycle err_valid=1, err_code=01, out_valid=0, data_out unchanged; pulsing err_clr gives err_valid=0 and err_code=00.
4. Timeout (TIMEOUT=16):
   - Stimulus: bit 0 never resolves.
   - Response: err_code=10 and err_valid=1 exactly after the 16th EVAL cycle; no out_valid.
5. Premature precharge:
   - Stimulus: precharge returns to 1 after 4 incomplete EVAL cycles.
   - Response: err_code=11.
   - Follow-up: evaluate without a preceding spacer; the word is ignored and out_valid stays 0.
6. Reset mid-operation and sync latency:
   - Stimulus: assert rst while in OUT.
   - Response: out_valid, err_valid and data_out go to 0 immediately.
   - With WDDL_DEC_SYNC_EN, repeating scenario 1 gives out_valid 3 cycles after completion.
